// File: rtl/tri_edge_sched_pkg.sv
// -----------------------------------------------------------------------------
// tri_edge_sched_pkg
// Shared types for the wireframe triangle scheduler: 2-D points, triangles,
// the scheduler state encoding and the index of the closing edge.
// Ports: none (package).
// -----------------------------------------------------------------------------
package tri_edge_sched_pkg;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
    } Point2D;

    typedef struct packed {
        Point2D v0;
        Point2D v1;
        Point2D v2;
    } Tri2D;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CULL,
        S_START,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } SchedState;

    // Edge index of v2->v0, the edge that closes the triangle.
    localparam logic [1:0] EDGE_LAST = 2'd2;

    // Two points coincide only when both coordinates match.
    function automatic logic points_equal(input Point2D a, input Point2D b);
        return (a.x == b.x) && (a.y == b.y);
    endfunction

endpackage

// File: rtl/tri_edge_sched_area.sv
// -----------------------------------------------------------------------------
// tri_area_sign
// Combinational back-face test. Computes the signed doubled area
//   A = (x1-x0)*(y2-y0) - (y1-y0)*(x2-x0)
// with 17-bit differences and a 35-bit result, and flags the triangle for
// culling when A <= 0 (clockwise or degenerate).
// Only exists when BACKFACE_CULL_EN is defined; the default build has no
// multiplier at all.
// Ports:
//   tri_i   in   Tri2D  triangle vertices
//   cull_o  out  1      1 = triangle faces away or has zero area
// -----------------------------------------------------------------------------
`ifdef BACKFACE_CULL_EN
module tri_area_sign
    import tri_edge_sched_pkg::*;
(
    input  Tri2D tri_i,
    output logic cull_o
);

    logic signed [16:0] dx1;
    logic signed [16:0] dy1;
    logic signed [16:0] dx2;
    logic signed [16:0] dy2;
    logic signed [33:0] prod_a;
    logic signed [33:0] prod_b;
    logic signed [34:0] area;

    // Differences are one bit wider than the coordinates so they cannot
    // overflow; each product fits 34 bits and the difference of two products
    // fits 35 bits.
    always_comb begin
        dx1    = {tri_i.v1.x[15], tri_i.v1.x} - {tri_i.v0.x[15], tri_i.v0.x};
        dy1    = {tri_i.v1.y[15], tri_i.v1.y} - {tri_i.v0.y[15], tri_i.v0.y};
        dx2    = {tri_i.v2.x[15], tri_i.v2.x} - {tri_i.v0.x[15], tri_i.v0.x};
        dy2    = {tri_i.v2.y[15], tri_i.v2.y} - {tri_i.v0.y[15], tri_i.v0.y};
        prod_a = 34'(dx1) * 34'(dy2);
        prod_b = 34'(dy1) * 34'(dx2);
        area   = {prod_a[33], prod_a} - {prod_b[33], prod_b};
        cull_o = area[34] | (area == '0);
    end

endmodule
`endif

// File: rtl/tri_edge_sched.sv
// -----------------------------------------------------------------------------
// tri_edge_sched
// Wireframe triangle scheduler in front of a Bresenham line engine. Accepts
// one triangle per valid/ready handshake, runs edges v0->v1, v1->v2, v2->v0
// through the engine with its start/done protocol and forwards the plotted
// pixels to the framebuffer writer, emitting each shared vertex only once.
//
// Optional feature: define BACKFACE_CULL_EN to drop triangles whose signed
// area is <= 0 during the CULL cycle (uses tri_area_sign).
//
// Parameters:
//   COLOR_W         width of the pass-through colour
//   TIMEOUT_CYCLES  WAIT cycles allowed per edge before the triangle aborts
// Ports:
//   clk, n_rst          clock (rising edge), async active-low reset
//   tri_valid/ready     triangle handshake; tri_in vertices, color_in colour
//   line_start          one-cycle start pulse to the engine
//   line_p / line_q     current edge endpoints, stable from start to done
//   line_plot/point     engine pixel strobe and coordinate
//   line_done           engine finished the current edge
//   pix_valid/point     registered pixel write, one cycle after line_plot
//   pix_color           colour latched at accept
//   tri_done            one-cycle pulse when a triangle finishes or is dropped
//   timeout_err         sticky watchdog flag, cleared by the next accept
//   pix_count           pixels emitted for the current/last triangle (sat.)
// -----------------------------------------------------------------------------
module tri_edge_sched
    import tri_edge_sched_pkg::*;
#(
    parameter int COLOR_W        = 8,
    parameter int TIMEOUT_CYCLES = 262143
)
(
    input  logic               clk,
    input  logic               n_rst,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  Tri2D               tri_in,
    input  logic [COLOR_W-1:0] color_in,
    output logic               line_start,
    output Point2D             line_p,
    output Point2D             line_q,
    input  logic               line_plot,
    input  Point2D             line_point,
    input  logic               line_done,
    output logic               pix_valid,
    output Point2D             pix_point,
    output logic [COLOR_W-1:0] pix_color,
    output logic               tri_done,
    output logic               timeout_err,
    output logic [15:0]        pix_count
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    SchedState          state_q, state_d;
    Tri2D               tri_q, tri_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [1:0]         edge_q, edge_d;
    logic               first_q, first_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               timeout_q, timeout_d;
    logic               pix_valid_q, pix_valid_d;
    Point2D             pix_point_q, pix_point_d;
    logic [15:0]        pix_count_q, pix_count_d;
    logic               clear_count;

`ifdef BACKFACE_CULL_EN
    logic cull_back;

    tri_area_sign u_area (
        .tri_i  (tri_q),
        .cull_o (cull_back)
    );
`endif

    // Edge endpoints are a pure function of the latched triangle and the edge
    // index, so they stay put for the whole START/WAIT window of an edge.
    always_comb begin
        line_p = tri_q.v2;
        line_q = tri_q.v0;
        case (edge_q)
            2'd0: begin
                line_p = tri_q.v0;
                line_q = tri_q.v1;
            end
            2'd1: begin
                line_p = tri_q.v1;
                line_q = tri_q.v2;
            end
            default: begin
                line_p = tri_q.v2;
                line_q = tri_q.v0;
            end
        endcase
    end

    // Scheduler FSM: next state, per-triangle bookkeeping and the handshake
    // strobes. The watchdog restarts at every START; a done arriving in the
    // same cycle as the timeout is treated as a normal completion.
    always_comb begin
        state_d     = state_q;
        tri_d       = tri_q;
        color_d     = color_q;
        edge_d      = edge_q;
        first_d     = first_q;
        wdog_d      = wdog_q;
        timeout_d   = timeout_q;
        tri_ready   = 1'b0;
        line_start  = 1'b0;
        tri_done    = 1'b0;
        clear_count = 1'b0;
        case (state_q)
            S_IDLE: begin
                tri_ready = 1'b1;
                if (tri_valid) begin
                    tri_d       = tri_in;
                    color_d     = color_in;
                    timeout_d   = 1'b0;
                    edge_d      = 2'd0;
                    clear_count = 1'b1;
                    state_d     = S_CULL;
                end
            end
            S_CULL: begin
`ifdef BACKFACE_CULL_EN
                state_d = cull_back ? S_FINISH : S_START;
`else
                state_d = S_START;
`endif
            end
            S_START: begin
                line_start = 1'b1;
                first_d    = 1'b1;
                wdog_d     = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (line_plot) begin
                    first_d = 1'b0;
                end
                if (line_done) begin
                    state_d = S_NEXT;
                end else if (wdog_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_NEXT: begin
                if (edge_q == EDGE_LAST) begin
                    state_d = S_FINISH;
                end else begin
                    edge_d  = edge_q + 2'd1;
                    state_d = S_START;
                end
            end
            S_FINISH: begin
                tri_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pixel filter. The first pixel of edges 1 and 2 is the vertex already
    // drawn by the previous edge; on the closing edge any pixel landing on v0
    // was drawn by edge 0. Matching v0 by value (not position) keeps the
    // dedup exact for degenerate triangles where v2 == v0.
    always_comb begin
        pix_valid_d = (state_q == S_WAIT) && line_plot
                      && !((edge_q != 2'd0) && first_q)
                      && !((edge_q == EDGE_LAST) && points_equal(line_point, tri_q.v0));
        pix_point_d = pix_valid_d ? line_point : pix_point_q;
        pix_count_d = pix_count_q;
        if (clear_count) begin
            pix_count_d = '0;
        end else if (pix_valid_d && (pix_count_q != 16'hFFFF)) begin
            pix_count_d = pix_count_q + 16'd1;
        end
    end

    // State and datapath registers; reset returns straight to IDLE with all
    // outputs cleared, abandoning any triangle in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            tri_q       <= '0;
            color_q     <= '0;
            edge_q      <= '0;
            first_q     <= 1'b0;
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_point_q <= '0;
            pix_count_q <= '0;
        end else begin
            state_q     <= state_d;
            tri_q       <= tri_d;
            color_q     <= color_d;
            edge_q      <= edge_d;
            first_q     <= first_d;
            wdog_q      <= wdog_d;
            timeout_q   <= timeout_d;
            pix_valid_q <= pix_valid_d;
            pix_point_q <= pix_point_d;
            pix_count_q <= pix_count_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_point   = pix_point_q;
    assign pix_color   = color_q;
    assign timeout_err = timeout_q;
    assign pix_count   = pix_count_q;

endmodule

// File: tb/tb_tri_edge_sched.sv
// -----------------------------------------------------------------------------
// tb_tri_edge_sched
// Self-checking bench for tri_edge_sched. A behavioural Bresenham engine
// answers the start/done protocol; expected pixel streams come from a
// reference model that draws the three edges and removes repeated vertices.
// -----------------------------------------------------------------------------
module tb_tri_edge_sched;
    import tri_edge_sched_pkg::*;

    localparam int COLOR_W    = 8;
    localparam int TMO        = 16;
    localparam int DONE_BOUND = 2000;
`ifdef BACKFACE_CULL_EN
    localparam bit CULL_ON = 1'b1;
`else
    localparam bit CULL_ON = 1'b0;
`endif

    logic               clk;
    logic               n_rst;
    logic               tri_valid;
    logic               tri_ready;
    Tri2D               tri_in;
    logic [COLOR_W-1:0] color_in;
    logic               line_start;
    Point2D             line_p;
    Point2D             line_q;
    logic               line_plot  = 1'b0;
    Point2D             line_point = '0;
    logic               line_done  = 1'b0;
    logic               pix_valid;
    Point2D             pix_point;
    logic [COLOR_W-1:0] pix_color;
    logic               tri_done;
    logic               timeout_err;
    logic [15:0]        pix_count;

    int checks = 0;
    int errors = 0;

    tri_edge_sched #(
        .COLOR_W        (COLOR_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .tri_valid   (tri_valid),
        .tri_ready   (tri_ready),
        .tri_in      (tri_in),
        .color_in    (color_in),
        .line_start  (line_start),
        .line_p      (line_p),
        .line_q      (line_q),
        .line_plot   (line_plot),
        .line_point  (line_point),
        .line_done   (line_done),
        .pix_valid   (pix_valid),
        .pix_point   (pix_point),
        .pix_color   (pix_color),
        .tri_done    (tri_done),
        .timeout_err (timeout_err),
        .pix_count   (pix_count)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hang guard: any runaway wait ends the run with a reported failure.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running, limit reached");
        $fatal(1, "[TB] stopped by hang guard");
    end

    function automatic Point2D mkPt(input int x, input int y);
        Point2D p;
        p.x = 16'(x);
        p.y = 16'(y);
        return p;
    endfunction

    // Behavioural line engine: on a start pulse, plots one Bresenham pixel per
    // cycle from line_p to line_q, then raises line_done for one cycle.
    // With engStall set it ignores starts entirely (watchdog scenario).
    bit engStall    = 1'b0;
    bit engActive   = 1'b0;
    bit engDonePend = 1'b0;
    int ecx, ecy, eex, eey, edx, edy, esx, esy, eerr, ee2;

    always @(negedge clk) begin
        line_done = 1'b0;
        if (!n_rst) begin
            engActive   = 1'b0;
            engDonePend = 1'b0;
            line_plot   = 1'b0;
        end else if (engActive) begin
            line_plot  = 1'b1;
            line_point = mkPt(ecx, ecy);
            if (ecx == eex && ecy == eey) begin
                engActive   = 1'b0;
                engDonePend = 1'b1;
            end else begin
                ee2 = 2 * eerr;
                if (ee2 >= edy) begin eerr += edy; ecx += esx; end
                if (ee2 <= edx) begin eerr += edx; ecy += esy; end
            end
        end else if (engDonePend) begin
            line_plot   = 1'b0;
            line_done   = 1'b1;
            engDonePend = 1'b0;
        end else begin
            line_plot = 1'b0;
            if (line_start && !engStall) begin
                ecx  = int'(line_p.x);
                ecy  = int'(line_p.y);
                eex  = int'(line_q.x);
                eey  = int'(line_q.y);
                edx  = (eex > ecx) ? eex - ecx : ecx - eex;
                edy  = (eey > ecy) ? ecy - eey : eey - ecy;
                esx  = (ecx < eex) ? 1 : -1;
                esy  = (ecy < eey) ? 1 : -1;
                eerr = edx + edy;
                engActive = 1'b1;
            end
        end
    end

    // Output monitor: collects every written pixel and counts handshake pulses.
    Point2D             gotPix[$];
    logic [COLOR_W-1:0] gotColor[$];
    int                 startCnt = 0;
    int                 doneCnt  = 0;

    always @(negedge clk) begin
        if (n_rst) begin
            if (pix_valid) begin
                gotPix.push_back(pix_point);
                gotColor.push_back(pix_color);
            end
            if (line_start) startCnt++;
            if (tri_done)   doneCnt++;
        end
    end

    // Reference model: the outline of a triangle is its three edges drawn in
    // order, with each vertex written once. Edges 1 and 2 start on a vertex
    // already drawn, and the closing edge ends on v0, drawn by edge 0.
    Point2D expPix[$];

    function automatic longint triArea(input Point2D a, input Point2D b, input Point2D c);
        longint x0, y0, x1, y1, x2, y2;
        x0 = longint'(a.x); y0 = longint'(a.y);
        x1 = longint'(b.x); y1 = longint'(b.y);
        x2 = longint'(c.x); y2 = longint'(c.y);
        return (x1 - x0) * (y2 - y0) - (y1 - y0) * (x2 - x0);
    endfunction

    function automatic void appendEdge(input Point2D a, input Point2D b,
                                       input bit dropStart, input bit dropV0,
                                       input Point2D v0);
        int x, y, x1, y1, dx, dy, sx, sy, err, e2;
        bit atStart;
        Point2D p;
        x  = int'(a.x);  y  = int'(a.y);
        x1 = int'(b.x);  y1 = int'(b.y);
        dx = (x1 > x) ? x1 - x : x - x1;
        dy = (y1 > y) ? y - y1 : y1 - y;
        sx = (x < x1) ? 1 : -1;
        sy = (y < y1) ? 1 : -1;
        err = dx + dy;
        atStart = 1'b1;
        while (1) begin
            p = mkPt(x, y);
            if (!(dropStart && atStart) && !(dropV0 && p == v0)) expPix.push_back(p);
            atStart = 1'b0;
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    function automatic bit isCulled(input Point2D a, input Point2D b, input Point2D c);
        return CULL_ON && (triArea(a, b, c) <= 0);
    endfunction

    function automatic void buildExpected(input Point2D a, input Point2D b, input Point2D c);
        expPix.delete();
        if (isCulled(a, b, c)) return;
        appendEdge(a, b, 1'b0, 1'b0, a);
        appendEdge(b, c, 1'b1, 1'b0, a);
        appendEdge(c, a, 1'b1, 1'b1, a);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Offers one triangle and returns at the negedge of the cycle after
    // acceptance (the CULL cycle), with tri_valid dropped.
    task automatic applyStimulus(input Point2D a, input Point2D b, input Point2D c,
                                 input logic [COLOR_W-1:0] col);
        int n;
        gotPix.delete();
        gotColor.delete();
        startCnt = 0;
        doneCnt  = 0;
        @(negedge clk);
        tri_in    = '{a, b, c};
        color_in  = col;
        tri_valid = 1'b1;
        n = 0;
        while (!tri_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tri_valid = 1'b0;
    endtask

    // From the CULL cycle: checks first-start latency, waits for tri_done and
    // compares the collected pixel stream with the model.
    task automatic postAccept(input string tag, input logic [COLOR_W-1:0] col,
                              input bit culled, input bit wantNoDup);
        int n, mism, dups;
        @(negedge clk);
        checkOutput({tag, ".start_latency"}, 64'(line_start), 64'(!culled));
        checkOutput({tag, ".cull_done"}, 64'(tri_done), 64'(culled));
        n = 0;
        while (!tri_done && n < DONE_BOUND) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, ".done_seen"}, 64'(tri_done), 64'(1));
        @(negedge clk);
        checkOutput({tag, ".done_pulses"}, 64'(doneCnt), 64'(1));
        checkOutput({tag, ".start_pulses"}, 64'(startCnt), culled ? 64'(0) : 64'(3));
        checkOutput({tag, ".pix_num"}, 64'(gotPix.size()), 64'(expPix.size()));
        checkOutput({tag, ".pix_count"}, 64'(pix_count), 64'(expPix.size()));
        mism = 0;
        for (int i = 0; i < gotPix.size() && i < expPix.size(); i++) begin
            if (gotPix[i] !== expPix[i]) mism++;
            if (gotColor[i] !== col) mism++;
        end
        checkOutput({tag, ".pix_stream_diffs"}, 64'(mism), 64'(0));
        if (wantNoDup) begin
            dups = 0;
            for (int i = 0; i < gotPix.size(); i++)
                for (int j = i + 1; j < gotPix.size(); j++)
                    if (gotPix[i] == gotPix[j]) dups++;
            checkOutput({tag, ".duplicates"}, 64'(dups), 64'(0));
        end
    endtask

    task automatic runTriangle(input string tag, input Point2D a, input Point2D b,
                               input Point2D c, input logic [COLOR_W-1:0] col,
                               input bit wantNoDup);
        buildExpected(a, b, c);
        applyStimulus(a, b, c, col);
        postAccept(tag, col, isCulled(a, b, c), wantNoDup);
    endtask

    typedef struct {
        Point2D             v0;
        Point2D             v1;
        Point2D             v2;
        logic [COLOR_W-1:0] col;
        int                 expCount;
        bit                 noDup;
    } TriVec;

    TriVec vecs[5];

    initial begin
        int n, seen, badReady;
        Point2D ra, rb, rc;

        vecs[0] = '{mkPt(0, 0), mkPt(4, 0), mkPt(0, 4), 8'hA5, 12, 1'b1};
        vecs[1] = '{mkPt(5, 5), mkPt(5, 5), mkPt(5, 5), 8'h3C, 1,  1'b1};
        vecs[2] = '{mkPt(0, 0), mkPt(2, 0), mkPt(2, 2), 8'h11, 6,  1'b1};
        vecs[3] = '{mkPt(1, 1), mkPt(1, 1), mkPt(4, 1), 8'h7E, 6,  1'b0};
        vecs[4] = '{mkPt(0, 0), mkPt(0, 4), mkPt(4, 0), 8'hC3, 12, 1'b1};

        n_rst     = 1'b0;
        tri_valid = 1'b0;
        tri_in    = '0;
        color_in  = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset.tri_ready", 64'(tri_ready), 64'(1));
        checkOutput("reset.line_start", 64'(line_start), 64'(0));
        checkOutput("reset.pix_valid", 64'(pix_valid), 64'(0));
        checkOutput("reset.tri_done", 64'(tri_done), 64'(0));
        checkOutput("reset.timeout_err", 64'(timeout_err), 64'(0));
        checkOutput("reset.pix_count", 64'(pix_count), 64'(0));
        checkOutput("reset.line_p", 64'(line_p), 64'(0));
        n_rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            runTriangle(tag, vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].col, vecs[i].noDup);
            checkOutput({tag, ".table_count"}, 64'(pix_count),
                        isCulled(vecs[i].v0, vecs[i].v1, vecs[i].v2) ? 64'(0) : 64'(vecs[i].expCount));
        end

        // tri_valid held high across two triangles.
        ra = mkPt(-3, -3); rb = mkPt(3, -2); rc = mkPt(0, 4);
        gotPix.delete(); gotColor.delete(); startCnt = 0; doneCnt = 0;
        @(negedge clk);
        tri_in    = '{vecs[0].v0, vecs[0].v1, vecs[0].v2};
        color_in  = 8'h55;
        tri_valid = 1'b1;
        @(negedge clk);
        tri_in   = '{ra, rb, rc};
        color_in = 8'h99;
        badReady = 0;
        n = 0;
        while (!tri_done && n < DONE_BOUND) begin
            if (tri_ready) badReady++;
            @(negedge clk);
            n++;
        end
        checkOutput("hold.first_done", 64'(tri_done), 64'(1));
        checkOutput("hold.ready_low_cycles", 64'(badReady), 64'(0));
        @(negedge clk);
        checkOutput("hold.ready_after_done", 64'(tri_ready), 64'(1));
        gotPix.delete(); gotColor.delete(); startCnt = 0; doneCnt = 0;
        buildExpected(ra, rb, rc);
        @(negedge clk);
        tri_valid = 1'b0;
        checkOutput("hold.second_accepted", 64'(tri_ready), 64'(0));
        postAccept("hold.second", 8'h99, isCulled(ra, rb, rc), 1'b0);

        // Engine never finishes: watchdog aborts after TMO WAIT cycles.
        engStall = 1'b1;
        applyStimulus(vecs[0].v0, vecs[0].v1, vecs[0].v2, 8'h21);
        @(negedge clk);
        checkOutput("tmo.start", 64'(line_start), 64'(1));
        n = 0;
        while (!tri_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tmo.start_to_done", 64'(n), 64'(TMO + 1));
        checkOutput("tmo.err_set", 64'(timeout_err), 64'(1));
        checkOutput("tmo.pix_count", 64'(pix_count), 64'(0));
        @(negedge clk);
        checkOutput("tmo.err_sticky", 64'(timeout_err), 64'(1));
        checkOutput("tmo.single_start", 64'(startCnt), 64'(1));
        engStall = 1'b0;
        buildExpected(vecs[2].v0, vecs[2].v1, vecs[2].v2);
        applyStimulus(vecs[2].v0, vecs[2].v1, vecs[2].v2, 8'h22);
        checkOutput("tmo.err_cleared", 64'(timeout_err), 64'(0));
        postAccept("tmo.recover", 8'h22, 1'b0, 1'b1);

        // Reset asserted in the middle of edge 1.
        applyStimulus(mkPt(0, 0), mkPt(10, 0), mkPt(10, 10), 8'hEE);
        seen = 0;
        n = 0;
        while (seen < 2 && n < 200) begin
            @(negedge clk);
            n++;
            if (line_start) seen++;
        end
        checkOutput("rst.reached_edge1", 64'(seen), 64'(2));
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        #1;
        checkOutput("rst.tri_ready", 64'(tri_ready), 64'(1));
        checkOutput("rst.line_start", 64'(line_start), 64'(0));
        checkOutput("rst.tri_done", 64'(tri_done), 64'(0));
        checkOutput("rst.pix_valid", 64'(pix_valid), 64'(0));
        checkOutput("rst.pix_count", 64'(pix_count), 64'(0));
        checkOutput("rst.pix_color", 64'(pix_color), 64'(0));
        checkOutput("rst.pix_point", 64'(pix_point), 64'(0));
        checkOutput("rst.line_q", 64'(line_q), 64'(0));
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        runTriangle("rst.after", vecs[0].v0, vecs[0].v1, vecs[0].v2, 8'h44, 1'b1);

        // Randomised triangles in a small window, so every edge fits the
        // short watchdog used here.
        for (int t = 0; t < 20; t++) begin
            ra = mkPt(int'($urandom_range(12)) - 6, int'($urandom_range(12)) - 6);
            rb = mkPt(int'($urandom_range(12)) - 6, int'($urandom_range(12)) - 6);
            rc = mkPt(int'($urandom_range(12)) - 6, int'($urandom_range(12)) - 6);
            runTriangle($sformatf("rand%0d", t), ra, rb, rc,
                        COLOR_W'($urandom_range(255)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
